// File: rtl/sda_kernel_param_fetch.sv
// Kernel parameter fetcher: on a run request, reads PARAM_COUNT words from
// parameter memory and then hands the run to the action core with the
// fetched words presented on params.
module sda_kernel_param_fetch #(
  parameter int unsigned PARAM_COUNT = 4,
  parameter logic [31:0] PARAM_BASE  = 32'h0000_0010
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        go_inReady,
  output logic                        go_inStop,
  output logic                        paramaddr_0Ready,
  output logic [31:0]                 paramaddr_0Data,
  input  logic                        paramaddr_0Stop,
  input  logic                        paramdata_0Ready,
  input  logic [31:0]                 paramdata_0Data,
  output logic                        paramdata_0Stop,
  output logic                        go_outReady,
  input  logic                        go_outStop,
  output logic [32*PARAM_COUNT-1:0]   params,
  output logic                        busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = $clog2(PARAM_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PARAM_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARAM_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LAUNCH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;

  logic              go_xfer, addr_xfer, data_xfer, out_xfer;

  logic              go_in_stop_d;
  logic              addr_valid_d;
  logic [31:0]       addr_d;
  logic              data_stop_d;
  logic              go_out_d;
  logic              busy_d;

  // Handshake completions, qualified by the registered Ready/Stop outputs
  assign go_xfer   = go_inReady       & ~go_inStop;
  assign addr_xfer = paramaddr_0Ready & ~paramaddr_0Stop;
  assign data_xfer = paramdata_0Ready & ~paramdata_0Stop;
  assign out_xfer  = go_outReady      & ~go_outStop;

  // Next-state, counter updates and next values of every registered output
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    data_cnt_d = data_cnt_q;

    case (state_q)
      IDLE: begin
        if (go_xfer) begin
          state_d    = FETCH;
          addr_cnt_d = '0;
          data_cnt_d = '0;
        end
      end
      FETCH: begin
        if (addr_xfer) begin
          addr_cnt_d = addr_cnt_q + CNT_W'(1);
        end
        if (data_xfer) begin
          data_cnt_d = data_cnt_q + CNT_W'(1);
          if (data_cnt_q == CNT_LAST) begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (out_xfer) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    go_in_stop_d = (state_d != IDLE);
    busy_d       = (state_d != IDLE);
    go_out_d     = (state_d == LAUNCH);
    addr_valid_d = (state_d == FETCH) && (addr_cnt_d < CNT_MAX);
    addr_d       = PARAM_BASE + (WORD_W'(addr_cnt_d) << 2);
    data_stop_d  = !((state_d == FETCH) && (data_cnt_d < CNT_MAX));
  end

  // State and counter registers
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  // Registered handshake outputs, decoded from the next state
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      go_inStop        <= 1'b0;
      busy             <= 1'b0;
      go_outReady      <= 1'b0;
      paramaddr_0Ready <= 1'b0;
      paramaddr_0Data  <= '0;
      paramdata_0Stop  <= 1'b1;
    end else begin
      go_inStop        <= go_in_stop_d;
      busy             <= busy_d;
      go_outReady      <= go_out_d;
      paramaddr_0Ready <= addr_valid_d;
      paramaddr_0Data  <= addr_d;
      paramdata_0Stop  <= data_stop_d;
    end
  end

  // Parameter words: each data transfer overwrites only the slot it fills
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      params <= '0;
    end else if (data_xfer) begin
      for (int i = 0; i < int'(PARAM_COUNT); i++) begin
        if (data_cnt_q == CNT_W'(i)) begin
          params[WORD_W*i +: WORD_W] <= paramdata_0Data;
        end
      end
    end
  end

endmodule
